agnus_sprite_dma: RTL and testbench
===================================

Name: agnus_sprite_dma

Overview:
- Sprite DMA sequencer on the Agnus side; it writes the per-sprite POS/CTL/DATA/DATB registers that the Denise sprite shifters consume.
- Holds the eight sprite pointers and runs one fetch state machine per sprite.
- On each sprite DMA slot it issues a chip-RAM word fetch, then forwards the fetched word as a sprite register write.
- Snoops the fetched POS/CTL words to extract the vertical start/stop lines.

Parameters:
- NSPR, 8, number of sprite channels (slot_num width fixed at 3).
- AW, 20, chip word-address width (dma_addr covers byte address bits [AW:1]).

Ports:
- clk  in  1  28MHz clock
- reset  in  1  reset, asynchronous, active-high
- clk7_en  in  1  7MHz enable; all state changes only when high
- dma_en  in  1  sprite DMA enable (DMACON SPREN & DMAEN)
- vbl_end  in  1  pulse on first DMA line after vertical blank
- vpos  in  9  current beam line
- slot_en  in  1  sprite DMA slot strobe
- slot_num  in  3  sprite owning the slot
- slot_word  in  1  0 = first word of pair, 1 = second
- ptr_wr  in  1  CPU write to SPRxPTH/L
- ptr_num  in  3  pointer select
- ptr_hi  in  1  1 = high half (bits AW:16), 0 = low half (15:1)
- ptr_din  in  16  CPU data
- chip_din  in  16  fetched chip word
- fmode  in  16  AGA fetch mode; bits [3:2] used
- dma_req  out  1  bus request, one clk7 period
- dma_addr  out  AW  word address of fetch
- reg_wr  out  1  sprite register write strobe (Denise aen)
- reg_num  out  3  target sprite
- reg_addr  out  2  00 POS, 01 CTL, 10 DATA, 11 DATB
- reg_dout  out  16  data for register write

Behaviour:
- Reset values: all outputs 0, pointers 0, vstart/vstop 0, every channel IDLE.
- Per-channel states: IDLE, CONTROL, WAIT, DATA.
  - vbl_end moves every channel to CONTROL.
  - CONTROL: word0 fetches POS, word1 fetches CTL, then the channel goes to WAIT.
  - WAIT: a slot with vpos==vstart moves the channel to DATA and fetches in that same slot.
  - DATA: word0 normally fetches DATA and word1 fetches DATB.
  - DATA exit: if vpos==vstop at word0, the pair fetches POS/CTL instead and the channel returns to WAIT.
  - vstart==vstop gives a zero-height sprite: DATA is entered and immediately reloads control.
- Slot pipeline:
  - A qualified slot is sampled at enabled cycle N.
  - N+1: dma_req=1, dma_addr=pointer, reg_num/reg_addr set; the pointer increments.
  - N+2: chip_din is captured into reg_dout; reg_wr=1 for one enabled cycle; a POS/CTL capture updates vstart/vstop.
  - A qualified slot requires dma_en=1, state!=IDLE and slot_num<NSPR.
  - Back-to-back slots overlap: request N+1 coexists with the write from the previous slot.
- Field extraction: vstart={CTL[2],POS[15:8]}; vstop={CTL[1],CTL[15:8]}.
- Pointer increment is 1 word, with wrap modulo 2^AW.
- ptr_wr loads the selected half at the enabled edge. If it coincides with a DMA increment of the same pointer, the CPU write wins.
- dma_en=0: no requests; states and pointers hold; an in-flight write still completes.
- A slot for an IDLE channel issues nothing.
- Reset is asynchronous: an in-flight request or write is dropped at once.

Optional Feature:
- Macro: AGA_SPRITE_FMODE_EN.
- When defined, the pointer increment follows fmode[3:2]: 00 -> 1 word, 01/10 -> 2 words, 11 -> 4 words.
- When defined, dma_addr is aligned to that width (low bits forced 0).
- Without it, fmode is ignored and the increment is always 1 word (OCS/ECS).

Decomposition:
- Shared package:
  - state encoding (IDLE/CONTROL/WAIT/DATA);
  - register address constants POS/CTL/DATA/DATB (same values as the sprite shifter);
  - the fmode-to-increment function.
- Natural sub-module agnus_sprite_channel, instanced NSPR times. It holds the state, vstart/vstop and pointer for one channel. The top level does the slot muxing and the output pipeline.

Test Plan:
- Pointer load and first fetch: load pointer 0 with 0x01000 (word address); vbl_end; slots 0/word0 and 0/word1 with chip words POS=0x4040, CTL=0x5000.
  - Expect requests at 0x01000 then 0x01001.
  - Expect reg_wr to addr 00 with 0x4040, then 01 with 0x5000.
  - Expect vstart=0x040, vstop=0x050.
- Start line: with vpos=0x03F, no requests; with vpos=0x040, DATA/DATB fetched at 0x01002/0x01003 on each line through 0x04F.
- Stop line: with vpos=0x050, word0 writes POS and word1 writes CTL; a new CTL with vstart==vstop gives one DATA-entry line, then an immediate control reload.
- dma_en=0 mid-frame: zero dma_req and frozen pointer; re-enabling resumes at the same address.
- Same-edge CPU write during an increment: ptr_wr of the low half = 0x2000 together with a DMA increment leaves the pointer at 0x2000/2.
- With AGA_SPRITE_FMODE_EN and fmode[3:2]=11: successive fetches are spaced 4 words apart. Reset asserted between request and write: reg_wr never pulses and all outputs clear asynchronously.

Source files
------------

// File: rtl/agnus_sprite_dma_pkg.sv
// Shared types for the Agnus sprite DMA sequencer: channel states, sprite register
// addresses (same encoding as the Denise sprite shifter) and the AGA fetch-width helper.
package agnus_sprite_dma_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StControl = 2'd1,
    StWait    = 2'd2,
    StData    = 2'd3
  } spr_state_e;

  localparam logic [1:0] RegPos  = 2'b00;
  localparam logic [1:0] RegCtl  = 2'b01;
  localparam logic [1:0] RegData = 2'b10;
  localparam logic [1:0] RegDatb = 2'b11;

  // Pointer step in words for fmode[3:2].
  function automatic logic [2:0] fmode_inc(input logic [1:0] fm);
    logic [2:0] inc;
    unique case (fm)
      2'b00:   inc = 3'd1;
      2'b01:   inc = 3'd2;
      2'b10:   inc = 3'd2;
      default: inc = 3'd4;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/agnus_sprite_dma_if.sv
// Chip-bus fetch and Denise sprite-register write signals of the sprite DMA sequencer.
interface agnus_sprite_dma_if #(
  parameter int unsigned AW = 20
);
  logic          dma_req;
  logic [AW-1:0] dma_addr;
  logic [15:0]   chip_din;
  logic          reg_wr;
  logic [2:0]    reg_num;
  logic [1:0]    reg_addr;
  logic [15:0]   reg_dout;

  modport master (
    output dma_req, dma_addr, reg_wr, reg_num, reg_addr, reg_dout,
    input  chip_din
  );

  modport slave (
    input  dma_req, dma_addr, reg_wr, reg_num, reg_addr, reg_dout,
    output chip_din
  );
endinterface

// File: rtl/agnus_sprite_channel.sv
// One sprite DMA channel: fetch state, vertical start/stop lines and the sprite pointer.
// Decides combinationally whether the current slot fetches and which register it targets.
module agnus_sprite_channel
  import agnus_sprite_dma_pkg::*;
#(
  parameter int unsigned AW = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk7_en,
  input  logic          vbl_end_i,
  input  logic          slot_hit_i,
  input  logic          slot_word_i,
  input  logic [8:0]    vpos_i,
  input  logic          ptr_wr_i,
  input  logic          ptr_hi_i,
  input  logic [15:0]   ptr_din_i,
  input  logic [AW-1:0] ptr_inc_i,
  input  logic          cap_en_i,
  input  logic [1:0]    cap_addr_i,
  input  logic [15:0]   cap_data_i,
  output logic          fetch_o,
  output logic [1:0]    fetch_reg_o,
  output logic [AW-1:0] ptr_o
);

  spr_state_e    state_q, state_d, state_eff;
  logic [8:0]    vstart_q, vstart_d, vstop_q, vstop_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          unused_cap;

  assign unused_cap = ^{cap_data_i[7:3], cap_data_i[0]};
  assign ptr_o      = ptr_q;

  always_comb begin
    state_d     = state_q;
    fetch_o     = 1'b0;
    fetch_reg_o = RegPos;
    // A WAIT channel reaching its start line behaves as DATA in the same slot.
    state_eff   = (state_q == StWait && vpos_i == vstart_q) ? StData : state_q;
    if (vbl_end_i) begin
      state_d = StControl;
    end else if (slot_hit_i) begin
      case (state_eff)
        StControl: begin
          fetch_o     = 1'b1;
          fetch_reg_o = slot_word_i ? RegCtl : RegPos;
          if (slot_word_i) state_d = StWait;
        end
        StData: begin
          fetch_o = 1'b1;
          if (!slot_word_i && vpos_i == vstop_q) begin
            fetch_reg_o = RegPos;
            state_d     = StControl;
          end else begin
            fetch_reg_o = slot_word_i ? RegDatb : RegData;
            state_d     = StData;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ptr_d = fetch_o ? ptr_q + ptr_inc_i : ptr_q;
    // A CPU write lands on the pre-increment pointer and overrides the DMA step.
    if (ptr_wr_i) begin
      ptr_d = ptr_hi_i ? {ptr_din_i[AW-16:0], ptr_q[14:0]} : {ptr_q[AW-1:15], ptr_din_i[15:1]};
    end
  end

  always_comb begin
    vstart_d = vstart_q;
    vstop_d  = vstop_q;
    if (cap_en_i) begin
      if (cap_addr_i == RegPos) begin
        vstart_d[7:0] = cap_data_i[15:8];
      end else if (cap_addr_i == RegCtl) begin
        vstart_d[8] = cap_data_i[2];
        vstop_d     = {cap_data_i[1], cap_data_i[15:8]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      vstart_q <= '0;
      vstop_q  <= '0;
      ptr_q    <= '0;
    end else if (clk7_en) begin
      state_q  <= state_d;
      vstart_q <= vstart_d;
      vstop_q  <= vstop_d;
      ptr_q    <= ptr_d;
    end
  end

endmodule

// File: rtl/agnus_sprite_dma.sv
// Agnus sprite DMA sequencer: slot muxing, chip fetch request and sprite register write pipeline.
// Build option AGA_SPRITE_FMODE_EN: pointer step and address alignment follow fmode[3:2].
module agnus_sprite_dma
  import agnus_sprite_dma_pkg::*;
#(
  parameter int unsigned NSPR = 8,
  parameter int unsigned AW   = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic        dma_en,
  input  logic        vbl_end,
  input  logic [8:0]  vpos,
  input  logic        slot_en,
  input  logic [2:0]  slot_num,
  input  logic        slot_word,
  input  logic        ptr_wr,
  input  logic [2:0]  ptr_num,
  input  logic        ptr_hi,
  input  logic [15:0] ptr_din,
  input  logic [15:0] fmode,
  agnus_sprite_dma_if.master bus
);

  logic [NSPR-1:0] fetch;
  logic [1:0]      fetch_reg [NSPR];
  logic [AW-1:0]   ptr       [NSPR];
  logic [AW-1:0]   inc, sel_ptr, launch_addr;
  logic [1:0]      sel_reg;
  logic            launch;

  logic          req_q, wr_q;
  logic [AW-1:0] req_addr_q;
  logic [2:0]    req_num_q, out_num_q, out_num_d;
  logic [1:0]    req_reg_q, out_addr_q, out_addr_d;
  logic [15:0]   dout_q;
  logic          unused_fmode;

`ifdef AGA_SPRITE_FMODE_EN
  assign inc          = AW'(fmode_inc(fmode[3:2]));
  assign launch_addr  = sel_ptr & ~(inc - AW'(1));
  assign unused_fmode = ^{fmode[15:4], fmode[1:0]};
`else
  assign inc          = AW'(1);
  assign launch_addr  = sel_ptr;
  assign unused_fmode = ^fmode;
`endif

  for (genvar i = 0; i < NSPR; i++) begin : g_ch
    agnus_sprite_channel #(
      .AW (AW)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .clk7_en     (clk7_en),
      .vbl_end_i   (vbl_end),
      .slot_hit_i  (clk7_en & slot_en & dma_en & (slot_num == 3'(i))),
      .slot_word_i (slot_word),
      .vpos_i      (vpos),
      .ptr_wr_i    (clk7_en & ptr_wr & (ptr_num == 3'(i))),
      .ptr_hi_i    (ptr_hi),
      .ptr_din_i   (ptr_din),
      .ptr_inc_i   (inc),
      .cap_en_i    (clk7_en & req_q & (req_num_q == 3'(i))),
      .cap_addr_i  (req_reg_q),
      .cap_data_i  (bus.chip_din),
      .fetch_o     (fetch[i]),
      .fetch_reg_o (fetch_reg[i]),
      .ptr_o       (ptr[i])
    );
  end

  // At most one channel fetches per slot.
  always_comb begin
    sel_reg = RegPos;
    sel_ptr = '0;
    for (int i = 0; i < NSPR; i++) begin
      if (fetch[i]) begin
        sel_reg = fetch_reg[i];
        sel_ptr = ptr[i];
      end
    end
  end

  assign launch = |fetch;

  // reg_num/reg_addr follow the write stage when a write and a new request overlap.
  always_comb begin
    out_num_d  = out_num_q;
    out_addr_d = out_addr_q;
    if (req_q) begin
      out_num_d  = req_num_q;
      out_addr_d = req_reg_q;
    end else if (launch) begin
      out_num_d  = slot_num;
      out_addr_d = sel_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q      <= 1'b0;
      req_addr_q <= '0;
      req_num_q  <= '0;
      req_reg_q  <= '0;
      wr_q       <= 1'b0;
      dout_q     <= '0;
      out_num_q  <= '0;
      out_addr_q <= '0;
    end else if (clk7_en) begin
      req_q <= launch;
      if (launch) begin
        req_addr_q <= launch_addr;
        req_num_q  <= slot_num;
        req_reg_q  <= sel_reg;
      end
      wr_q <= req_q;
      if (req_q) dout_q <= bus.chip_din;
      out_num_q  <= out_num_d;
      out_addr_q <= out_addr_d;
    end
  end

  assign bus.dma_req  = req_q;
  assign bus.dma_addr = req_addr_q;
  assign bus.reg_wr   = wr_q;
  assign bus.reg_num  = out_num_q;
  assign bus.reg_addr = out_addr_q;
  assign bus.reg_dout = dout_q;

endmodule

// File: tb/tb_agnus_sprite_dma.sv
// Scoreboard bench for agnus_sprite_dma: stimulus queues expected fetches/writes, a monitor
// plays chip RAM and checks every dma_req and reg_wr against the queues.
module tb_agnus_sprite_dma;

  localparam int unsigned AW = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk7_en = 1'b0;
  logic        dma_en = 1'b0;
  logic        vbl_end = 1'b0;
  logic [8:0]  vpos = '0;
  logic        slot_en = 1'b0;
  logic [2:0]  slot_num = '0;
  logic        slot_word = 1'b0;
  logic        ptr_wr = 1'b0;
  logic [2:0]  ptr_num = '0;
  logic        ptr_hi = 1'b0;
  logic [15:0] ptr_din = '0;
  logic [15:0] fmode = '0;
  int          ph = 0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] exp_req [$];
  logic [20:0]   exp_wr  [$];
  bit   [15:0]   mem     [int];

  agnus_sprite_dma_if #(.AW(AW)) bus ();

  agnus_sprite_dma #(
    .NSPR (8),
    .AW   (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk7_en   (clk7_en),
    .dma_en    (dma_en),
    .vbl_end   (vbl_end),
    .vpos      (vpos),
    .slot_en   (slot_en),
    .slot_num  (slot_num),
    .slot_word (slot_word),
    .ptr_wr    (ptr_wr),
    .ptr_num   (ptr_num),
    .ptr_hi    (ptr_hi),
    .ptr_din   (ptr_din),
    .fmode     (fmode),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 4;
      clk7_en = (ph == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mdat(input logic [AW-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a[15:0] ^ 16'hA5A5;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic en_edge();
    do @(posedge clk); while (!clk7_en);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) en_edge();
  endtask

  task automatic slot(input logic [2:0] n, input logic w);
    slot_num  = n;
    slot_word = w;
    slot_en   = 1'b1;
    en_edge();
    slot_en   = 1'b0;
  endtask

  task automatic pair(input logic [2:0] n);
    slot(n, 1'b0);
    slot(n, 1'b1);
  endtask

  task automatic ptr_load(input logic [2:0] n, input logic hi, input logic [15:0] d);
    ptr_num = n;
    ptr_hi  = hi;
    ptr_din = d;
    ptr_wr  = 1'b1;
    en_edge();
    ptr_wr  = 1'b0;
  endtask

  task automatic exp_fetch(input logic [AW-1:0] a, input logic [2:0] n, input logic [1:0] r);
    exp_req.push_back(a);
    exp_wr.push_back({n, r, mdat(a)});
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dma_req"},  32'(bus.dma_req),  32'd0);
    check({tag, "_dma_addr"}, 32'(bus.dma_addr), 32'd0);
    check({tag, "_reg_wr"},   32'(bus.reg_wr),   32'd0);
    check({tag, "_reg_num"},  32'(bus.reg_num),  32'd0);
    check({tag, "_reg_addr"}, 32'(bus.reg_addr), 32'd0);
    check({tag, "_reg_dout"}, 32'(bus.reg_dout), 32'd0);
  endtask

  // Monitor: chip RAM model plus scoreboard pop/compare.
  initial begin
    logic [20:0]   e;
    logic [AW-1:0] a;
    bus.chip_din = '0;
    forever begin
      do @(posedge clk); while (!clk7_en);
      #2;
      if (!reset) begin
        if (bus.reg_wr) begin
          if (exp_wr.size() == 0) begin
            check("unexpected_reg_wr", 32'(bus.reg_addr), 32'hFFFF_FFFF);
          end else begin
            e = exp_wr.pop_front();
            check("wr_num",  32'(bus.reg_num),  32'(e[20:18]));
            check("wr_addr", 32'(bus.reg_addr), 32'(e[17:16]));
            check("wr_data", 32'(bus.reg_dout), 32'(e[15:0]));
          end
        end
        if (bus.dma_req) begin
          if (exp_req.size() == 0) begin
            check("unexpected_dma_req", 32'(bus.dma_addr), 32'hFFFF_FFFF);
          end else begin
            a = exp_req.pop_front();
            check("req_addr", 32'(bus.dma_addr), 32'(a));
          end
          bus.chip_din = mdat(bus.dma_addr);
        end
      end
    end
  end

  initial begin
    mem[int'(20'h01000)] = 16'h4040;
    mem[int'(20'h01001)] = 16'h5000;
    mem[int'(20'h01022)] = 16'h6060;
    mem[int'(20'h01023)] = 16'h6000;
    mem[int'(20'h01024)] = 16'h7070;
    mem[int'(20'h01025)] = 16'h8000;
    mem[int'(20'h08008)] = 16'h1234;
    mem[int'(20'h08009)] = 16'h0006;

    step(2);
    check_outputs_zero("reset");
    reset  = 1'b0;
    dma_en = 1'b1;
    step(1);

    // Channel still IDLE: no fetch.
    pair(3'd0);
    step(3);

    ptr_load(3'd0, 1'b1, 16'h0000);
    ptr_load(3'd0, 1'b0, 16'h2000);
    ptr_load(3'd3, 1'b1, 16'h0001);
    ptr_load(3'd3, 1'b0, 16'h0010);
    ptr_load(3'd5, 1'b1, 16'h001F);
    ptr_load(3'd5, 1'b0, 16'hFFFE);
    ptr_load(3'd6, 1'b0, 16'h0106);

    vbl_end = 1'b1;
    step(1);
    vbl_end = 1'b0;

    exp_fetch(20'h01000, 3'd0, 2'b00);
    exp_fetch(20'h01001, 3'd0, 2'b01);
    pair(3'd0);

    // Interleaved channels 3 and 5; channel 5 pointer wraps to 0.
    exp_fetch(20'h08008, 3'd3, 2'b00);
    exp_fetch(20'hFFFFF, 3'd5, 2'b00);
    exp_fetch(20'h08009, 3'd3, 2'b01);
    exp_fetch(20'h00000, 3'd5, 2'b01);
    slot(3'd3, 1'b0);
    slot(3'd5, 1'b0);
    slot(3'd3, 1'b1);
    slot(3'd5, 1'b1);
    step(2);

    vpos = 9'h03F;
    pair(3'd0);
    step(2);

    for (int l = 'h40; l <= 'h4F; l++) begin
      vpos = 9'(l);
      exp_fetch(AW'(32'h01002 + 2 * (l - 'h40)),     3'd0, 2'b10);
      exp_fetch(AW'(32'h01002 + 2 * (l - 'h40) + 1), 3'd0, 2'b11);
      pair(3'd0);
    end

    vpos = 9'h050;
    exp_fetch(20'h01022, 3'd0, 2'b00);
    exp_fetch(20'h01023, 3'd0, 2'b01);
    pair(3'd0);
    step(2);

    // Zero-height sprite (vstart == vstop == 0x060).
    vpos = 9'h05F;
    pair(3'd0);
    step(2);
    vpos = 9'h060;
    exp_fetch(20'h01024, 3'd0, 2'b00);
    exp_fetch(20'h01025, 3'd0, 2'b01);
    pair(3'd0);
    step(2);

    // Channel 3 start line uses CTL bit 2 as vstart[8].
    vpos = 9'h112;
    exp_fetch(20'h0800A, 3'd3, 2'b10);
    exp_fetch(20'h0800B, 3'd3, 2'b11);
    pair(3'd3);
    step(2);

    dma_en = 1'b0;
    vpos   = 9'h070;
    pair(3'd0);
    step(2);
    dma_en = 1'b1;
    exp_fetch(20'h01026, 3'd0, 2'b10);
    exp_fetch(20'h01027, 3'd0, 2'b11);
    pair(3'd0);

    // CPU low-half write on the same edge as a DMA increment.
    vpos = 9'h071;
    exp_fetch(20'h01028, 3'd0, 2'b10);
    ptr_num = 3'd0;
    ptr_hi  = 1'b0;
    ptr_din = 16'h2000;
    ptr_wr  = 1'b1;
    slot(3'd0, 1'b0);
    ptr_wr  = 1'b0;
    exp_fetch(20'h01000, 3'd0, 2'b11);
    slot(3'd0, 1'b1);
    step(2);

    fmode = 16'h000C;
`ifdef AGA_SPRITE_FMODE_EN
    exp_fetch(20'h00080, 3'd6, 2'b00);
    exp_fetch(20'h00084, 3'd6, 2'b01);
`else
    exp_fetch(20'h00083, 3'd6, 2'b00);
    exp_fetch(20'h00084, 3'd6, 2'b01);
`endif
    pair(3'd6);
    step(3);
    fmode = 16'h0000;

    // Reset between request and write: the write must never appear.
    exp_req.push_back(20'h00000);
    slot(3'd7, 1'b0);
    check("req_before_reset", 32'(bus.dma_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    step(3);
    reset = 1'b0;
    step(4);

    check("req_queue_empty", 32'(exp_req.size()), 32'd0);
    check("wr_queue_empty",  32'(exp_wr.size()),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
